// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: size codes, decoder control-word
// field positions, FSM state encoding and the request legality check.
package mau_pkg;

    localparam logic [1:0] SZ_WORD    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_BYTE    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Bit positions of the memory fields inside the 15-bit decoder control word.
    localparam int CW_SIZE_HI   = 6;
    localparam int CW_SIZE_LO   = 5;
    localparam int CW_MEM_WRITE = 4;
    localparam int CW_MEM_READ  = 3;
    localparam int CW_LB_LH     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } mau_state_e;

    function automatic logic mau_req_err(input logic [1:0] size,
                                         input logic       rd,
                                         input logic       wr,
                                         input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size == SZ_ILLEGAL)                      bad = 1'b1;
        if (rd && wr)                                bad = 1'b1;
        if (size == SZ_HALF && addr_lo[0])           bad = 1'b1;
        if (size == SZ_WORD && addr_lo != 2'b00)     bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-addressed data-memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if #(
    parameter int AW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mau_lane.sv
// Combinational byte-lane logic: load extract/extend, read-modify-write merge,
// store-data replication and byte-enable generation (little-endian lanes).
module mau_lane
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        load_signed,
    input  logic [31:0] bus_rdata,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] merged,
    output logic [31:0] repl,
    output logic [3:0]  be
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = bus_rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ld_data  = bus_rdata;
        merged   = st_data;
        repl     = st_data;
        be       = 4'hF;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{load_signed & byte_sel[7]}}, byte_sel};
                merged  = bus_rdata;
                merged[{addr_lo, 3'b000} +: 8] = st_data[7:0];
                repl    = {4{st_data[7:0]}};
                be      = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                ld_data = {{16{load_signed & half_sel[15]}}, half_sel};
                merged  = bus_rdata;
                merged[{addr_lo[1], 4'b0000} +: 16] = st_data[15:0];
                repl    = {2{st_data[15:0]}};
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                ld_data = bus_rdata;
                merged  = st_data;
                repl    = st_data;
                be      = 4'hF;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store engine on a 32-bit word bus. Define MAU_BYTE_ENABLE_EN to
// issue sub-word stores as a single byte-enabled write instead of read-modify-write.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    size,
    input  logic          mem_write,
    input  logic          mem_read,
    input  logic          load_signed,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    mem_access_unit_if.master bus
);

    mau_state_e    state_q, state_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;

    logic [1:0]    size_q, size_d;
    logic          load_q, load_d;
    logic          signed_q, signed_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          req_err;
    logic          idle;
    logic [1:0]    lane_size;
    logic [1:0]    lane_addr;
    logic [31:0]   lane_st;
    logic [31:0]   lane_ld;
    logic [31:0]   lane_merged;
    logic [31:0]   lane_repl;
    logic [3:0]    lane_be;

    // The lane block sees the live request while idle and the captured one afterwards.
    assign idle      = (state_q == ST_IDLE);
    assign req_err   = mau_req_err(size, mem_read, mem_write, addr[1:0]);
    assign lane_size = idle ? size      : size_q;
    assign lane_addr = idle ? addr[1:0] : addr_lo_q;
    assign lane_st   = idle ? wdata     : wdata_q;

    mau_lane u_lane (
        .size        (lane_size),
        .addr_lo     (lane_addr),
        .load_signed (signed_q),
        .bus_rdata   (bus.mem_rdata),
        .st_data     (lane_st),
        .ld_data     (lane_ld),
        .merged      (lane_merged),
        .repl        (lane_repl),
        .be          (lane_be)
    );

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        size_d      = size_q;
        load_d      = load_q;
        signed_d    = signed_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    size_d     = size;
                    load_d     = mem_read;
                    signed_d   = load_signed;
                    addr_lo_d  = addr[1:0];
                    wdata_d    = wdata;
                    rdata_d    = '0;
                    err_d      = req_err;
                    mem_addr_d = addr[AW-1:2];
                    if (req_err || (!mem_read && !mem_write)) begin
                        state_d = ST_DONE;
                    end else if (mem_read) begin
                        state_d   = ST_RD;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        mem_be_d  = 4'hF;
                    end else begin
`ifdef MAU_BYTE_ENABLE_EN
                        state_d     = ST_WR;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = lane_repl;
                        mem_be_d    = lane_be;
`else
                        mem_req_d = 1'b1;
                        mem_be_d  = 4'hF;
                        if (size == SZ_WORD) begin
                            state_d     = ST_WR;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = wdata;
                        end else begin
                            state_d  = ST_RD;
                            mem_we_d = 1'b0;
                        end
`endif
                    end
                end
            end
            ST_RD: begin
                if (bus.mem_ack) begin
                    if (load_q) begin
                        state_d   = ST_DONE;
                        rdata_d   = lane_ld;
                        mem_req_d = 1'b0;
                        mem_be_d  = 4'h0;
                    end else begin
                        // Sub-word store: write back the fetched word with the new lane merged in.
                        state_d     = ST_WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = lane_merged;
                    end
                end
            end
            ST_WR: begin
                if (bus.mem_ack) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'h0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    // Request capture registers are only read after an accept, so they need no reset.
    always_ff @(posedge clk) begin
        size_q    <= size_d;
        load_q    <= load_d;
        signed_q  <= signed_d;
        addr_lo_q <= addr_lo_d;
        wdata_q   <= wdata_d;
    end

    assign ready         = idle;
    assign done          = (state_q == ST_DONE);
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Multicycle load/store engine that executes the memory fields of the 15-bit control word produced by the instruction decoder: size, store, load, signed-load.
- Takes one request from the execute stage and performs the word-bus transaction(s) on a 32-bit word-addressed data memory.
- Returns extended load data, or an error, with a one-cycle `done` pulse.
- On the word-only bus, sub-word stores are done as read-modify-write.

## Interface
Parameters:
- `AW`, 32, byte-address width.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request strobe; sampled only when `ready`=1.
- `size`  in  2  access size, decoder Size field (control bits [6:5]): 00 word, 01 half, 10 byte, 11 illegal.
- `mem_write`  in  1  store (control bit 4).
- `mem_read`  in  1  load (control bit 3).
- `load_signed`  in  1  sign-extend the load (control bit 2): 1 for lb/lh, 0 for lbu/lhu.
- `addr`  in  AW  byte address.
- `wdata`  in  32  store data, right-justified.
- `ready`  out  1  idle; accepts `start`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: misaligned or illegal request.
- `rdata`  out  32  extended load data, valid with `done`.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  AW-2  word address, `addr[AW-1:2]`.
- `mem_wdata`  out  32  bus write data.
- `mem_be`  out  4  byte enables.
- `mem_rdata`  in  32  bus read data, valid when `mem_ack`=1.
- `mem_ack`  in  1  bus acknowledge; completes the current beat.

## Operation
- Byte lanes are little-endian: byte `addr[1:0]`=k occupies bits [8k+7:8k]; a halfword at `addr[1]`=h occupies [16h+15:16h].
- On an accepted `start`, `size`, `mem_write`, `mem_read`, `load_signed`, `addr` and `wdata` are registered. Later input changes are ignored.
- Request validity is checked in the accept cycle. A request is an error when any of these holds:
  - `size`=11;
  - `mem_read`=`mem_write`=1;
  - half access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0.
  An error request goes to DONE with `err`=1 and makes no bus access.
- A request with `mem_read`=`mem_write`=0 is a no-op: DONE with `err`=0 and no bus access.
- States:
  - IDLE: `ready`=1. The request is routed to RD for a load or sub-word store, to WR for a word store, or to DONE for an error or no-op.
  - RD: `mem_req`=1, `mem_we`=0. On `mem_ack`, a load latches the extracted, extended lane; a sub-word store latches `mem_rdata` with the new byte/half merged in. Next state is DONE for a load, WR for a store.
  - WR: `mem_req`=1, `mem_we`=1. On `mem_ack`, go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `rdata` extension: byte and half are zero- or sign-extended per `load_signed`; a word is passed through. Stores and errors return `rdata`=0.
- `mem_addr` is the same word address in RD and WR.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `err`=0, `rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` are registered and held stable until the cycle in which `mem_ack`=1. `mem_req` drops, or moves to the next beat, on the following edge.
- `mem_ack` is ignored while `mem_req`=0.
- Latency from the accept edge N, with zero-wait ack (ack in the first request cycle):
  - load: `done` at N+2;
  - word store: `done` at N+2;
  - RMW store: `done` at N+3;
  - error/no-op: `done` at N+1.
  Each wait cycle adds one.
- `ready` is low from N+1 through the DONE cycle, and high again the cycle after `done`.
- `rst` asserted in any state returns IDLE on that edge. Any in-flight beat is abandoned, no `done` is issued, and a late `mem_ack` is ignored.

## Configuration
- `MAU_BYTE_ENABLE_EN` defined:
  - sub-word stores skip RD and issue one WR beat;
  - `mem_wdata` carries the data replicated across all lanes (byte ×4, half ×2);
  - `mem_be` selects the target lanes (e.g. 0100 for a byte at `addr[1:0]`=2).
- Not defined:
  - `mem_be` is 1111 on every beat and 0 when idle;
  - sub-word stores use RD→WR read-modify-write.
- Loads and error handling are identical in both builds.

## Structure
- Shared package `mau_pkg`:
  - size codes SZ_WORD=00, SZ_HALF=01, SZ_BYTE=10;
  - control-word field positions (Size [6:5], MemWrite 4, MemRead 3, lb_lh 2);
  - state encodings IDLE/RD/WR/DONE.
- Sub-module `mau_lane`: purely combinational lane extract/extend (load) and lane merge / byte-enable generation (store). The FSM stays in `mem_access_unit`.

## Test plan
- Load byte signed: memory word 0x1234_80FF, `addr`=0x101, `size`=10, `load_signed`=1, zero-wait ack → `rdata`=0xFFFF_FF80, `done` at N+2, one read beat to word address 0x40.
- Load half unsigned: same word, `addr`=0x102, `size`=01, `load_signed`=0, two wait cycles → `rdata`=0x0000_1234, `done` at N+4.
- Store byte, macro off: word 0xAABB_CCDD, `addr`=0x201, `wdata`=0x55 → read beat then write beat with `mem_wdata`=0xAABB_55DD, `mem_be`=1111. Macro on → single write beat, `mem_wdata`=0x5555_5555, `mem_be`=0010.
- Misaligned word load at `addr`=0x102 → `done`=1 and `err`=1 at N+1, `mem_req` never asserted.
- `rst` pulsed in RD while `mem_ack`=0, then ack arrives → no `done`, `mem_req`=0 after the reset edge, `ready`=1, and the next request completes normally.
- `start` held high across back-to-back word stores → second request accepted only in the cycle after the first `done`.
